// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - MIPS ALU issue stage: decode, 32x32 GRF, drive external ALU, write back.
// Define ALU_ISSUE_FAST_EN to drop the WB state (3-cycle latency instead of 4).
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_c,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

    state_t      state_q;
    logic [31:0] instr_q;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic [2:0]  alu_op_q;
    logic        wb_valid_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    logic        illegal_q;
    logic [31:0] grf_q [32];

    function automatic logic is_legal(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        case (w[31:26])
            OPC_RTYPE: begin
                case (w[5:0])
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SRLV, FN_SRAV: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OPC_ADDIU, OPC_ORI, OPC_LUI: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [15:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign rs_idx = instr_q[25:21];
    assign rt_idx = instr_q[20:16];
    assign rd_idx = instr_q[15:11];
    assign imm    = instr_q[15:0];
    // Entry 0 is never written, so it reads as zero without a special case.
    assign rs_val = grf_q[rs_idx];
    assign rt_val = grf_q[rt_idx];

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [2:0]  dec_op;
    logic [4:0]  dec_dest;
    logic        dec_legal;

    assign dec_legal = is_legal(instr_q);

    always_comb begin
        dec_a    = rs_val;
        dec_b    = rt_val;
        dec_op   = ALU_ADD;
        dec_dest = rd_idx;
        case (instr_q[31:26])
            OPC_RTYPE: begin
                case (instr_q[5:0])
                    FN_SUBU: dec_op = ALU_SUB;
                    FN_AND:  dec_op = ALU_AND;
                    FN_OR:   dec_op = ALU_OR;
                    FN_SRLV: begin
                        dec_a  = rt_val;
                        dec_b  = {27'b0, rs_val[4:0]};
                        dec_op = ALU_SRL;
                    end
                    FN_SRAV: begin
                        dec_a  = rt_val;
                        dec_b  = {27'b0, rs_val[4:0]};
                        dec_op = ALU_SRA;
                    end
                    default: dec_op = ALU_ADD;
                endcase
            end
            OPC_ADDIU: begin
                dec_b    = {{16{imm[15]}}, imm};
                dec_dest = rt_idx;
            end
            OPC_ORI: begin
                dec_b    = {16'b0, imm};
                dec_op   = ALU_OR;
                dec_dest = rt_idx;
            end
            OPC_LUI: begin
                dec_a    = {imm, 16'b0};
                dec_b    = 32'b0;
                dec_op   = ALU_OR;
                dec_dest = rt_idx;
            end
            default: dec_dest = rd_idx;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                grf_q[i] <= '0;
            end
        end else begin
            illegal_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Legality is checked on the incoming word so illegal pulses in the DECODE cycle.
                    if (instr_valid) begin
                        instr_q   <= instr;
                        illegal_q <= !is_legal(instr);
                        state_q   <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        alu_a_q   <= dec_a;
                        alu_b_q   <= dec_b;
                        alu_op_q  <= dec_op;
                        wb_addr_q <= dec_dest;
                        state_q   <= EXEC;
`ifdef ALU_ISSUE_FAST_EN
                        wb_valid_q <= 1'b1;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
`ifdef ALU_ISSUE_FAST_EN
                EXEC: begin
                    if (wb_addr_q != 5'd0) begin
                        grf_q[wb_addr_q] <= alu_c;
                    end
                    wb_data_q <= alu_c;
                    state_q   <= IDLE;
                end
`else
                EXEC: begin
                    wb_data_q  <= alu_c;
                    wb_valid_q <= 1'b1;
                    state_q    <= WB;
                end
                WB: begin
                    if (wb_addr_q != 5'd0) begin
                        grf_q[wb_addr_q] <= wb_data_q;
                    end
                    state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign illegal     = illegal_q;
`ifdef ALU_ISSUE_FAST_EN
    assign wb_data     = wb_valid_q ? alu_c : wb_data_q;
`else
    assign wb_data     = wb_data_q;
`endif
    assign dbg_rdata   = (dbg_raddr == 5'd0) ? 32'b0 : grf_q[dbg_raddr];

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized scoreboard bench for alu_issue with an instruction-level reference model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_c;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_raddr = '0;
    logic [31:0] dbg_rdata;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_c       (alu_c),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef ALU_ISSUE_FAST_EN
    localparam int WB_LAT     = 1;
    localparam int BUSY_LEGAL = 2;
`else
    localparam int WB_LAT     = 2;
    localparam int BUSY_LEGAL = 3;
`endif

    // The combinational ALU that sits beside the block.
    always_comb begin
        case (alu_op)
            3'b000:  alu_c = alu_a + alu_b;
            3'b001:  alu_c = alu_a - alu_b;
            3'b010:  alu_c = alu_a & alu_b;
            3'b011:  alu_c = alu_a | alu_b;
            3'b100:  alu_c = alu_a >> alu_b[4:0];
            3'b101:  alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_c = '0;
        endcase
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          ill;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    logic [31:0] mgrf [32];

    function automatic void model(input logic [31:0] w, output bit ill,
                                  output logic [4:0] d, output logic [31:0] r);
        logic [31:0] s;
        logic [31:0] t;
        s   = mgrf[w[25:21]];
        t   = mgrf[w[20:16]];
        ill = 1'b0;
        d   = w[20:16];
        r   = '0;
        case (w[31:26])
            6'h00: begin
                d = w[15:11];
                case (w[5:0])
                    6'h21:   r = s + t;
                    6'h23:   r = s - t;
                    6'h24:   r = s & t;
                    6'h25:   r = s | t;
                    6'h06:   r = t >> s[4:0];
                    6'h07:   r = $unsigned($signed(t) >>> s[4:0]);
                    default: ill = 1'b1;
                endcase
            end
            6'h09:   r = s + {{16{w[15]}}, w[15:0]};
            6'h0d:   r = s | {16'h0, w[15:0]};
            6'h0f:   r = {w[15:0], 16'h0};
            default: ill = 1'b1;
        endcase
        if (!ill && d != 5'd0) mgrf[d] = r;
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        logic [4:0] sh;
        sh = 5'($urandom);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (wb_valid || illegal)) begin
            check("wb_illegal_exclusive", {31'b0, wb_valid && illegal}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_event_count", 32'd1, {31'b0, 1'b0} + 32'(sb.size()));
            end else begin
                e = sb.pop_front();
                check("event_kind_illegal", {31'b0, illegal}, {31'b0, e.ill});
                check("event_cycle", cyc, e.cyc);
                if (!e.ill) begin
                    check("wb_addr", {27'b0, wb_addr}, {27'b0, e.addr});
                    check("wb_data", wb_data, e.data);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] w, input bit hold);
        int   waitc;
        int   busy;
        bit   ill;
        logic [4:0]  d;
        logic [31:0] r;
        exp_t e;
        waitc = 0;
        @(negedge clk);
        while (!instr_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_before_issue", {31'b0, instr_ready}, 32'd1);
        if (!instr_ready) return;
        instr_valid = 1'b1;
        instr = w;
        @(posedge clk);
        #1;
        model(w, ill, d, r);
        e.ill  = ill;
        e.addr = d;
        e.data = r;
        e.cyc  = cyc + (ill ? 0 : WB_LAT);
        sb.push_back(e);
        if (hold) instr = $urandom;
        else instr_valid = 1'b0;
        busy = 0;
        @(negedge clk);
        while (!instr_ready && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("busy_cycles", busy, ill ? 32'd1 : 32'(BUSY_LEGAL));
    endtask

    task automatic dbg_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        dbg_raddr = a;
        #1;
        check(name, dbg_rdata, exp);
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_ready"},    {31'b0, instr_ready}, 32'd1);
        check({tag, "_alu_a"},    alu_a, 32'd0);
        check({tag, "_alu_b"},    alu_b, 32'd0);
        check({tag, "_alu_op"},   {29'b0, alu_op}, 32'd0);
        check({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd0);
        check({tag, "_wb_addr"},  {27'b0, wb_addr}, 32'd0);
        check({tag, "_wb_data"},  wb_data, 32'd0);
        check({tag, "_illegal"},  {31'b0, illegal}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mgrf[i] = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_reset("reset");
        dbg_check("reset_dbg_r1", 5'd1, 32'd0);
        rst_n = 1'b1;

        issue(itype(6'h0d, 5'd0, 5'd1, 16'h1234), 1'b0);
        issue(itype(6'h0f, 5'd0, 5'd2, 16'h8000), 1'b0);
        issue(itype(6'h09, 5'd2, 5'd3, 16'hffff), 1'b0);
        issue(itype(6'h0f, 5'd0, 5'd4, 16'h8000), 1'b0);
        issue(itype(6'h0d, 5'd0, 5'd5, 16'h0024), 1'b0);
        issue(rtype(5'd5, 5'd4, 5'd6, 6'h07), 1'b0);
        issue(rtype(5'd5, 5'd4, 5'd7, 6'h06), 1'b0);
        issue(rtype(5'd1, 5'd1, 5'd0, 6'h21), 1'b0);
        issue(itype(6'h23, 5'd1, 5'd2, 16'h0000), 1'b1);
        issue(itype(6'h0d, 5'd1, 5'd9, 16'h0001), 1'b1);

        dbg_check("dir_r1_ori",   5'd1, 32'h0000_1234);
        dbg_check("dir_r2_lui",   5'd2, 32'h8000_0000);
        dbg_check("dir_r3_wrap",  5'd3, 32'h7fff_ffff);
        dbg_check("dir_r6_srav",  5'd6, 32'hf800_0000);
        dbg_check("dir_r7_srlv",  5'd7, 32'h0800_0000);
        dbg_check("dir_r0_zero",  5'd0, 32'h0000_0000);
        dbg_check("dir_r9_ori",   5'd9, 32'h0000_1235);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] w;
            logic [4:0]  ra, rb, rc;
            int          k;
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rc = 5'($urandom_range(0, 7));
            k  = $urandom_range(0, 9);
            case (k)
                0:       w = rtype(ra, rb, rc, 6'h21);
                1:       w = rtype(ra, rb, rc, 6'h23);
                2:       w = rtype(ra, rb, rc, 6'h24);
                3:       w = rtype(ra, rb, rc, 6'h25);
                4:       w = rtype(ra, rb, rc, 6'h06);
                5:       w = rtype(ra, rb, rc, 6'h07);
                6:       w = itype(6'h09, ra, rb, 16'($urandom));
                7:       w = itype(6'h0d, ra, rb, 16'($urandom));
                8:       w = itype(6'h0f, ra, rb, 16'($urandom));
                default: w = $urandom;
            endcase
            issue(w, ($urandom_range(0, 3) == 0));
        end

        for (int i = 0; i < 32; i++) dbg_check("rand_grf", 5'(i), mgrf[i]);

        @(negedge clk);
        instr_valid = 1'b1;
        instr = itype(6'h0d, 5'd0, 5'd8, 16'h0005);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("exec_before_reset_busy", {31'b0, instr_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_outputs_reset("midreset");
        instr_valid = 1'b1;
        instr = itype(6'h0d, 5'd0, 5'd9, 16'h0007);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_reset("heldreset");
        instr_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) mgrf[i] = '0;
        repeat (6) @(negedge clk);
        dbg_check("after_reset_r8", 5'd8, 32'd0);
        dbg_check("after_reset_r9", 5'd9, 32'd0);

        issue(itype(6'h0d, 5'd0, 5'd8, 16'h0005), 1'b0);
        dbg_check("recover_r8", 5'd8, 32'd5);
        for (int i = 0; i < 32; i++) dbg_check("final_grf", 5'(i), mgrf[i]);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
